mem_line_responder: RTL
=======================

# mem_line_responder

Memory-side responder for cache line refills and writebacks. It accepts line-granular requests from the cache miss logic on a 128-bit valid/ready request channel and returns read data on a 128-bit valid/ready response channel. It owns the backing single-port main-memory array of MEM_SIZE_Q quadwords. Each line is MEM_TRANSFERS_PER_CL (4) beats, and the block sits between the I$/D$ arbiter and the memory array.

## Interface
Parameters:
- AW, MEM_ADDR_BUS (12), quadword address width.
- DW, MEM_DATA_BUS (128), beat width.
- BEATS, MEM_TRANSFERS_PER_CL (4), beats per line; must satisfy is_pow2.
- DEPTH, MEM_SIZE_Q (4096), array depth in quadwords; equals 2**AW.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request beat valid.
- req_ready  out  1  request beat accepted when high together with req_valid.
- req_addr  in  AW  quadword address. The low log2(BEATS) bits are ignored and only the first beat's address is used.
- req_rtype  in  1  dmem_rtype_t; sampled on the first beat only.
- req_wdata  in  DW  write beat data.
- rsp_valid  out  1  read beat valid.
- rsp_ready  in  1  read beat consumed.
- rsp_data  out  DW  read beat data.
- wr_done  out  1  single-cycle pulse when a write line has completed.

## Operation
- Line base is req_addr[AW-1:2]. The beat index b (0..3) is appended as the low bits, and beats always run b=0..3 in order.
- FSM states:
  - IDLE: req_ready=1. On a handshake with READ, latch the line and set issue_cnt=0, then go to RD. On a handshake with WRITE, write req_wdata to beat 0, set wcnt=1, then go to WR.
  - WR: req_ready=1. Each handshake writes req_wdata to beat wcnt and increments wcnt. req_addr and req_rtype are ignored. The handshake with wcnt==3 goes to IDLE and asserts wr_done in the following cycle.
  - RD: req_ready=0.
    - A read to beat issue_cnt is issued whenever (fifo_cnt - pop + inflight) < 2, where pop = rsp_valid & rsp_ready.
    - Returned SRAM data is pushed into a 2-entry output FIFO. The FIFO head drives rsp_data, and rsp_valid = FIFO non-empty.
    - The FSM returns to IDLE in the cycle after the 4th beat is popped.
- inflight is at most 1, and the FIFO never overflows.
- rsp_data is held stable while rsp_valid & !rsp_ready.
- Simultaneous push and pop on the FIFO is legal; occupancy is unchanged.
- Reset:
  - rst forces IDLE, clears the FIFO, counters, inflight and wr_done, and drops rsp_valid immediately.
  - req_ready is 0 while rst is high.
  - Array contents are not reset.
  - A line in progress when reset hits is abandoned. Beats already written stay written.
- Address arithmetic wraps modulo DEPTH only through the AW field; line 0x3FF (quads 0xFFC..0xFFF) does not alias line 0.

## Timing
- Reset values: req_ready=0 during reset and 1 in the first cycle after release; rsp_valid=0; rsp_data=0; wr_done=0.
- Read, with the request handshake in cycle T:
  - Beat 0 address reaches the SRAM in T+1, SRAM data arrives in T+2, and rsp_valid is asserted from T+3.
  - With rsp_ready held high, beats appear in T+3..T+6, one per cycle.
  - Back in IDLE with req_ready=1 at T+7.
- Backpressure: each cycle of rsp_ready=0 delays all later beats by exactly one cycle. No beat is lost or duplicated.
- Write: four handshakes, which may be non-consecutive. The SRAM write occurs on the handshake edge. wr_done is high in the cycle after the 4th handshake, when req_ready is already 1 (IDLE).
- A read issued in the same cycle as a write to the same address is impossible, because RD and WR are exclusive.

## Structure
- Shared types package gets:
  - mem_rsp_state_t enum (IDLE, RD, WR).
  - MEM_RSP_FIFO_DEPTH = 2.
- The block reuses the package's MEM_ADDR_BUS, MEM_DATA_BUS, MEM_TRANSFERS_PER_CL, MEM_SIZE_Q and dmem_rtype_t.
- One sub-module, sram_sp_sync: single-port DEPTH×DW array with synchronous read (1-cycle latency) and a write-enable. It is instantiated once.
- The FIFO, counters and FSM are inline in mem_line_responder.

## Test plan
- Write then read: write line req_addr=0x010 with beats 0x…A0, A1, A2, A3 (rsp_ready=1) -> wr_done pulses once, 1 cycle after the 4th handshake. A later read of 0x010 returns A0, A1, A2, A3 in order.
- Streaming read latency: read handshake at cycle T with rsp_ready=1 -> rsp_valid in T+3..T+6 and req_ready=1 at T+7.
- Backpressure: after beat 0, hold rsp_ready=0 for 5 cycles, then toggle 1/0 -> rsp_data is stable while stalled, exactly 4 beats arrive in order, and inflight+FIFO never exceeds 2.
- Ignored low bits: read with req_addr=0x013 -> beats of quads 0x010..0x013 starting at beat 0. Also, a write whose beats 2..4 carry a different req_addr and req_rtype=READ still writes line 0x010.
- Top line: write and read line 0xFFC with distinct data, then read line 0x000 -> line 0x000 is unchanged and line 0xFFC data is correct.
- Reset mid-operation: assert rst after beat 1 of a read -> rsp_valid drops in the same cycle. After release, req_ready=1 and state is IDLE. A new read of the previously written line returns the original data.

Source files
------------

// File: rtl/mem_line_responder_pkg.sv
// rtl/mem_line_responder_pkg.sv - shared types and sizes for the memory line responder
//
// Purpose: bus widths, line geometry, request type and responder FSM state
// encoding shared by mem_line_responder and its SRAM.
package mem_line_responder_pkg;

    localparam int MEM_ADDR_BUS         = 12;
    localparam int MEM_DATA_BUS         = 128;
    localparam int MEM_TRANSFERS_PER_CL = 4;
    localparam int MEM_SIZE_Q           = 4096;
    localparam int MEM_RSP_FIFO_DEPTH   = 2;

    typedef enum logic {
        DMEM_READ  = 1'b0,
        DMEM_WRITE = 1'b1
    } dmem_rtype_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } mem_rsp_state_t;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/mem_line_responder_sram_sp_sync.sv
// rtl/mem_line_responder_sram_sp_sync.sv - single-port synchronous-read memory array
//
// Purpose: DEPTH x DW array, one access per cycle, read data valid the cycle
// after en. Contents are never reset.
// Ports:
//   clk   in  clock
//   en    in  read enable (rdata updates on the next edge)
//   we    in  write enable
//   addr  in  AW-bit word address shared by read and write
//   wdata in  DW-bit write data
//   rdata out DW-bit registered read data
module sram_sp_sync
    import mem_line_responder_pkg::*;
#(
    parameter int AW    = MEM_ADDR_BUS,
    parameter int DW    = MEM_DATA_BUS,
    parameter int DEPTH = MEM_SIZE_Q
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_line_responder.sv
// rtl/mem_line_responder.sv - cache line refill/writeback responder over a single-port array
//
// Purpose: accepts 4-beat line writes and line reads, owns the backing array.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   request beat handshake
//   req_addr          quadword address (low beat bits ignored, first beat only)
//   req_rtype         READ/WRITE, first beat only
//   req_wdata         write beat data
//   rsp_valid/ready   read beat handshake
//   rsp_data          read beat data (output FIFO head)
//   wr_done           one-cycle pulse after the last write beat
module mem_line_responder
    import mem_line_responder_pkg::*;
#(
    parameter int AW    = MEM_ADDR_BUS,
    parameter int DW    = MEM_DATA_BUS,
    parameter int BEATS = MEM_TRANSFERS_PER_CL,
    parameter int DEPTH = MEM_SIZE_Q
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic          req_rtype,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          wr_done
);

    localparam int BW = $clog2(BEATS);
    localparam int LW = AW - BW;
    localparam int CW = BW + 1;   // read counters must reach BEATS

    mem_rsp_state_t state, state_nxt;

    logic [LW-1:0] line_q;
    logic [CW-1:0] issue_cnt;
    logic [CW-1:0] pop_cnt;
    logic [BW-1:0] wcnt;
    logic          inflight;

    // Two-entry output FIFO; 1-bit pointers are enough for depth 2.
    logic [DW-1:0] fifo_mem [MEM_RSP_FIFO_DEPTH];
    logic          fifo_wptr;
    logic          fifo_rptr;
    logic [1:0]    fifo_cnt;

    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_rdata;

    logic          req_hs;
    logic          pop;
    logic          push;
    logic          issue;
    logic          is_write;
    logic [2:0]    occ_now;
    logic [2:0]    occ_lim;

    assign req_ready = (state != RD) && !rst;
    assign req_hs    = req_valid && req_ready;
    assign rsp_valid = (fifo_cnt != 2'd0);
    assign rsp_data  = fifo_mem[fifo_rptr];
    assign pop       = rsp_valid && rsp_ready;
    assign push      = inflight;   // SRAM data arrives the cycle after issue
    assign is_write  = (dmem_rtype_t'(req_rtype) == DMEM_WRITE);

    // Credit check: (fifo_cnt - pop + inflight) < depth, rearranged to avoid underflow.
    assign occ_now = {1'b0, fifo_cnt} + {2'b00, inflight};
    assign occ_lim = 3'(MEM_RSP_FIFO_DEPTH) + {2'b00, pop};
    assign issue   = (state == RD) && (issue_cnt < CW'(BEATS)) && (occ_now < occ_lim);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sram_en   = 1'b0;
        sram_we   = 1'b0;
        sram_addr = '0;
        case (state)
            IDLE: begin
                // Mask rather than slice so the ignored low bits are still consumed.
                sram_addr = req_addr & ~AW'(BEATS - 1);
                if (req_hs) begin
                    if (is_write) begin
                        sram_we   = 1'b1;
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            WR: begin
                sram_addr = {line_q, wcnt};
                if (req_hs) begin
                    sram_we = 1'b1;
                    if (wcnt == BW'(BEATS - 1)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            RD: begin
                sram_addr = {line_q, issue_cnt[BW-1:0]};
                sram_en   = issue;
                if (pop && (pop_cnt == CW'(BEATS - 1))) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q    <= '0;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            wcnt      <= '0;
            inflight  <= 1'b0;
            fifo_wptr <= 1'b0;
            fifo_rptr <= 1'b0;
            fifo_cnt  <= 2'd0;
            wr_done   <= 1'b0;
            for (int i = 0; i < MEM_RSP_FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            wr_done <= (state == WR) && req_hs && (wcnt == BW'(BEATS - 1));
            if ((state == IDLE) && req_hs) begin
                line_q    <= req_addr[AW-1:BW];
                issue_cnt <= '0;
                pop_cnt   <= '0;
                wcnt      <= BW'(1);
            end else if ((state == WR) && req_hs) begin
                wcnt <= wcnt + BW'(1);
            end
            if (issue) begin
                issue_cnt <= issue_cnt + CW'(1);
            end
            inflight <= issue;
            if (pop) begin
                pop_cnt   <= pop_cnt + CW'(1);
                fifo_rptr <= ~fifo_rptr;
            end
            if (push) begin
                fifo_mem[fifo_wptr] <= sram_rdata;
                fifo_wptr           <= ~fifo_wptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    sram_sp_sync #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (sram_addr),
        .wdata (req_wdata),
        .rdata (sram_rdata)
    );

endmodule
